uart_tx_buffered: RTL and testbench

Parametrised UART transmitter with an integrated synchronous FIFO. It is the next generation of the buffered TX path on the PC link and is used to stream plotter status and telemetry bytes to the host. Compared with the fixed 8N1 TX+FIFO pair, it adds:
- configurable data width, FIFO depth and baud rate;
- runtime parity and stop-bit selection;
- FIFO fill level and overflow reporting;
- deterministic bit timing, with the baud divider restarted on every frame.

---
 rtl/uart_tx_buffered.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : UART transmitter with integrated FWFT FIFO, runtime parity/stop
//            selection and fill-level/overflow reporting. Optional clear-to-send
//            flow control is enabled by defining UART_TX_CTS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef UART_TX_CTS_EN
    input  logic                  cts_n,
`endif
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  push,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_fifo_full,
    output logic                  tx_fifo_empty,
    output logic [ADDR_WIDTH:0]   tx_fifo_level,
    output logic                  tx_overflow
);

    localparam int TICK_RAW = CLK_HZ / (BAUD * 16);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BCW      = $clog2(DATA_WIDTH);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
    logic                  ovf_q;
    logic                  full, empty, pop, push_acc;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                        (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    // A pop in the same cycle frees a slot, so a push while full is still taken.
    assign push_acc   = push && (!full || pop);
    assign fifo_rdata = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    // ------------------------------------------------------- flow control
    logic cts_ok;
`ifdef UART_TX_CTS_EN
    logic cts_meta_q, cts_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign cts_ok = ~cts_sync_q;
`else
    assign cts_ok = 1'b1;
`endif

    // ------------------------------------------------------- transmitter
    state_t                state_q, state_d;
    logic [TCW-1:0]        tick_cnt_q;
    logic [4:0]            os_q, os_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  tick, os_last, bit_end;

    assign pop     = (state_q == S_IDLE) && !empty && cts_ok;
    assign tick    = (tick_cnt_q == TCW'(TICK_DIV - 1));
    assign os_last = (state_q == S_STOP && stop2_q) ? (os_q == 5'd31) : (os_q == 5'd15);
    assign bit_end = tick && os_last;

    // Restarting the divider on pop gives every bit exactly 16*TICK_DIV clocks.
    always_ff @(posedge clk) begin
        if (reset || pop || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            os_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_q      <= os_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    // tx_d carries the level of the bit that begins on the next edge.
    always_comb begin
        state_d   = state_q;
        os_d      = os_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE && tick) begin
            os_d = bit_end ? 5'd0 : os_q + 5'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    os_d      = '0;
                    bit_cnt_d = '0;
                    shift_d   = fifo_rdata;
                    par_en_d  = parity_mode[0] ^ parity_mode[1];
                    par_bit_d = (^fifo_rdata) ^ (parity_mode == 2'b10);
                    stop2_d   = stop2;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx            = tx_q;
    assign tx_busy       = (state_q != S_IDLE);
    assign tx_done       = done_q;
    assign tx_fifo_full  = full;
    assign tx_fifo_empty = empty;
    assign tx_fifo_level = wr_ptr_q - rd_ptr_q;
    assign tx_overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Directed self-checking bench for uart_tx_buffered (TICK_DIV=1,
//            depth 4). Connects cts_n when UART_TX_CTS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_buffered;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          push = 1'b0;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop2 = 1'b0;
    logic          tx, tx_busy, tx_done, tx_fifo_full, tx_fifo_empty, tx_overflow;
    logic [AW:0]   tx_fifo_level;
`ifdef UART_TX_CTS_EN
    logic          cts_n = 1'b0;
`endif

    uart_tx_buffered #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CLK_HZ     (1_600_000),
        .BAUD       (100_000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef UART_TX_CTS_EN
        .cts_n         (cts_n),
`endif
        .tx_data       (tx_data),
        .push          (push),
        .parity_mode   (parity_mode),
        .stop2         (stop2),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_level (tx_fifo_level),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered just after the edge on which tx fell, minus 'skip' cycles already spent.
    task automatic frame_check(input string tag, input logic [15:0] exp_bits,
                               input int nbits, input int skip);
        logic [15:0] got;
        logic        busy_all;
        got      = '0;
        busy_all = 1'b1;
        step(8 - skip);
        for (int k = 0; k < nbits; k++) begin
            if (k > 0) step(16);
            got[k]   = tx;
            busy_all = busy_all & tx_busy;
        end
        check({tag, "_bits"}, got, exp_bits);
        check({tag, "_busy"}, busy_all, 1'b1);
        step(7);
        check({tag, "_done_early"}, tx_done, 1'b0);
        step(1);
        check({tag, "_done"}, tx_done, 1'b1);
        check({tag, "_idle_busy"}, tx_busy, 1'b0);
        check({tag, "_idle_tx"}, tx, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                        input logic [15:0] exp_bits, input int nbits, input string tag);
        tx_data     = d;
        parity_mode = pm;
        stop2       = s2;
        push        = 1'b1;
        step(1);
        push = 1'b0;
        check({tag, "_prepop_level"}, tx_fifo_level, 3'd1);
        check({tag, "_prepop_tx"}, tx, 1'b1);
        step(1);
        check({tag, "_start_tx"}, tx, 1'b0);
        check({tag, "_start_busy"}, tx_busy, 1'b1);
        // Settings changed mid-frame must not affect this frame.
        parity_mode = ~pm;
        stop2       = ~s2;
        frame_check(tag, exp_bits, nbits, 0);
        step(1);
        check({tag, "_done_pulse"}, tx_done, 1'b0);
        parity_mode = 2'b00;
        stop2       = 1'b0;
        step(2);
    endtask

    logic [7:0] seq [5];
    int dones, lows;

    initial begin
        seq = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

        step(3);
        reset = 1'b0;
        step(3);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_empty", tx_fifo_empty, 1'b1);
        check("rst_full", tx_fifo_full, 1'b0);
        check("rst_level", tx_fifo_level, 3'd0);
        check("rst_ovf", tx_overflow, 1'b0);

        send(8'hA5, 2'b00, 1'b0, 16'h034A, 10, "a5_none");
        send(8'h03, 2'b01, 1'b0, 16'h0406, 11, "03_even");
        send(8'h03, 2'b10, 1'b1, 16'h0E06, 12, "03_odd_s2");
        send(8'h5A, 2'b11, 1'b1, 16'h06B4, 11, "5a_none_s2");

        // Six back-to-back pushes into a depth-4 FIFO while idle.
        tx_data = 8'h11; push = 1'b1; step(1);
        tx_data = 8'h22; step(1);
        tx_data = 8'h33; step(1);
        tx_data = 8'h44; step(1);
        tx_data = 8'h55; step(1);
        tx_data = 8'h66; step(1);
        push = 1'b0;
        check("burst_full", tx_fifo_full, 1'b1);
        check("burst_level", tx_fifo_level, 3'd4);
        check("burst_ovf", tx_overflow, 1'b1);
        check("burst_empty", tx_fifo_empty, 1'b0);
        frame_check("b11", {6'd0, 1'b1, 8'h11, 1'b0}, 10, 4);

        // First idle cycle: pop and push coincide while full.
        tx_data = 8'h77; push = 1'b1;
        step(1);
        push = 1'b0;
        check("pp_gap_tx", tx, 1'b0);
        check("pp_level", tx_fifo_level, 3'd4);
        check("pp_full", tx_fifo_full, 1'b1);
        check("pp_ovf", tx_overflow, 1'b1);
        for (int i = 0; i < 5; i++) begin
            frame_check($sformatf("b%0h", seq[i]), {6'd0, 1'b1, seq[i], 1'b0}, 10, 0);
            if (i < 4) begin
                step(1);
                check($sformatf("gap%0d_tx", i), tx, 1'b0);
            end
        end
        step(1);
        check("drain_empty", tx_fifo_empty, 1'b1);
        check("drain_level", tx_fifo_level, 3'd0);
        check("drain_tx", tx, 1'b1);

        // Reset in the middle of data bit 3 with a second byte queued.
        step(5);
        tx_data = 8'hF0; push = 1'b1; step(1);
        tx_data = 8'h0F; step(1);
        push = 1'b0;
        check("mid_level", tx_fifo_level, 3'd1);
        step(68);
        check("mid_busy", tx_busy, 1'b1);
        check("mid_tx_bit3", tx, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mrst_tx", tx, 1'b1);
        check("mrst_busy", tx_busy, 1'b0);
        check("mrst_level", tx_fifo_level, 3'd0);
        check("mrst_ovf", tx_overflow, 1'b0);
        check("mrst_done", tx_done, 1'b0);
        dones = 0;
        lows  = 0;
        repeat (200) begin
            step(1);
            dones += int'(tx_done);
            lows  += int'(!tx);
        end
        check("mrst_no_done", dones, 0);
        check("mrst_line_idle", lows, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
